// File: rtl/usb_enc_pkg.sv
// Shared types and constants for the USB packet encoder: FSM states, PID classes,
// SYNC pattern and CRC polynomials/presets.
package usb_enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_TOK,
        ST_CRC5,
        ST_DATA,
        ST_CRC16
    } state_t;

    typedef enum logic [1:0] {
        TOKEN,
        DATA,
        PID_ONLY
    } pid_class_t;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [4:0]  CRC5_POLY    = 5'b00101;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [4:0]  CRC5_INIT    = 5'b11111;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    // The two low PID bits alone decide what follows the PID on the wire.
    function automatic pid_class_t pid_class(input logic [3:0] pid);
        pid_class_t cls;
        case (pid[1:0])
            2'b01:   cls = TOKEN;
            2'b11:   cls = DATA;
            default: cls = PID_ONLY;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial CRC LFSR: feedback is the MSB xor the incoming bit, shifted left and
// folded into bit 0 and every polynomial tap.
module usb_crc_lfsr #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_reg;
    logic [WIDTH-1:0] crc_next;
    logic             fb;

    assign fb = crc_reg[WIDTH-1] ^ bit_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            if (gi == 0) begin : g_lsb
                assign crc_next[gi] = fb;
            end else begin : g_hi
                assign crc_next[gi] = crc_reg[gi-1] ^ (fb & POLY[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            crc_reg <= INIT;
        end else if (clr) begin
            crc_reg <= INIT;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/usb_pkt_serializer.sv
// USB transmit packet encoder: latches a descriptor and streams SYNC, PID, token
// or payload and the matching CRC as LSB-first NRZ bits under valid/ready.
module usb_pkt_serializer
    import usb_enc_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_pid,
    input  logic [10:0]            in_tok,
    input  logic [LEN_W-1:0]       in_len,
    input  logic [8*MAX_BYTES-1:0] in_data,
    output logic                   out_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   pkt_done,
    output logic                   len_err
);

    localparam int               CNT_W   = $clog2(8*MAX_BYTES + 1);
    localparam int               DATA_W  = 8*MAX_BYTES;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [3:0]          pid_reg, pid_next;
    logic [10:0]         tok_reg, tok_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [7:0]          byte_reg, byte_next;
    logic                pkt_done_reg, pkt_done_next;
    logic                len_err_reg, len_err_next;

    logic                accept;
    logic                fire;
    logic                last_bit;
    pid_class_t          cls;
    logic [CNT_W-1:0]    data_cnt;
    logic [4:0]          crc5;
    logic [15:0]         crc16;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign last_bit  = (cnt_reg == '0);
    assign cls       = pid_class(pid_reg);
    assign data_cnt  = CNT_W'({len_reg, 3'b000}) - CNT_W'(1);
    assign pkt_done  = pkt_done_reg;
    assign len_err   = len_err_reg;

    usb_crc_lfsr #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (accept),
        .en     (fire && (state_reg == ST_TOK)),
        .bit_in (out_bit),
        .crc    (crc5)
    );

    usb_crc_lfsr #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (accept),
        .en     (fire && (state_reg == ST_DATA)),
        .bit_in (out_bit),
        .crc    (crc16)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pid_next      = pid_reg;
        tok_next      = tok_reg;
        len_next      = len_reg;
        data_next     = data_reg;
        byte_next     = byte_reg;
        pkt_done_next = 1'b0;
        len_err_next  = 1'b0;
        out_bit       = 1'b0;
        out_last      = 1'b0;

        // Every field branch below overrides this on its final bit, so it never wraps.
        if (fire && !last_bit) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next   = ST_SYNC;
                    cnt_next     = CNT_W'(7);
                    byte_next    = SYNC_PATTERN;
                    pid_next     = in_pid;
                    tok_next     = in_tok;
                    data_next    = in_data;
                    len_next     = (in_len > MAX_LEN) ? MAX_LEN : in_len;
                    len_err_next = (in_len > MAX_LEN);
                end
            end
            ST_SYNC: begin
                out_bit = byte_reg[0];
                if (fire) begin
                    byte_next = {1'b0, byte_reg[7:1]};
                    if (last_bit) begin
                        state_next = ST_PID;
                        cnt_next   = CNT_W'(7);
                        byte_next  = {~pid_reg, pid_reg};
                    end
                end
            end
            ST_PID: begin
                out_bit  = byte_reg[0];
                out_last = last_bit && (cls == PID_ONLY);
                if (fire) begin
                    byte_next = {1'b0, byte_reg[7:1]};
                    if (last_bit) begin
                        case (cls)
                            TOKEN: begin
                                state_next = ST_TOK;
                                cnt_next   = CNT_W'(10);
                            end
                            DATA: begin
                                state_next = (len_reg == '0) ? ST_CRC16 : ST_DATA;
                                cnt_next   = (len_reg == '0) ? CNT_W'(15) : data_cnt;
                            end
                            default: begin
                                state_next    = ST_IDLE;
                                cnt_next      = '0;
                                pkt_done_next = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_TOK: begin
                out_bit = tok_reg[0];
                if (fire) begin
                    tok_next = {1'b0, tok_reg[10:1]};
                    if (last_bit) begin
                        state_next = ST_CRC5;
                        cnt_next   = CNT_W'(4);
                    end
                end
            end
            ST_CRC5: begin
                out_bit  = ~crc5[cnt_reg[2:0]];
                out_last = last_bit;
                if (fire && last_bit) begin
                    state_next    = ST_IDLE;
                    cnt_next      = '0;
                    pkt_done_next = 1'b1;
                end
            end
            ST_DATA: begin
                out_bit = data_reg[0];
                if (fire) begin
                    data_next = {1'b0, data_reg[DATA_W-1:1]};
                    if (last_bit) begin
                        state_next = ST_CRC16;
                        cnt_next   = CNT_W'(15);
                    end
                end
            end
            ST_CRC16: begin
                out_bit  = ~crc16[cnt_reg[3:0]];
                out_last = last_bit;
                if (fire && last_bit) begin
                    state_next    = ST_IDLE;
                    cnt_next      = '0;
                    pkt_done_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            pid_reg      <= '0;
            tok_reg      <= '0;
            len_reg      <= '0;
            data_reg     <= '0;
            byte_reg     <= '0;
            pkt_done_reg <= 1'b0;
            len_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pid_reg      <= pid_next;
            tok_reg      <= tok_next;
            len_reg      <= len_next;
            data_reg     <= data_next;
            byte_reg     <= byte_next;
            pkt_done_reg <= pkt_done_next;
            len_err_reg  <= len_err_next;
        end
    end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Randomised bench for usb_pkt_serializer: a wire-level packet model builds the
// expected bit stream and the observed accepted bits are compared against it.
module tb_usb_pkt_serializer;

    localparam int MB = 64;
    localparam int LW = $clog2(MB + 1);
    localparam int DW = 8 * MB;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_pid = '0;
    logic [10:0]   in_tok = '0;
    logic [LW-1:0] in_len = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_bit;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          pkt_done;
    logic          len_err;

    int total = 0;
    int bad = 0;
    bit exp_q[$];
    bit msg_q[$];

    usb_pkt_serializer #(.MAX_BYTES(MB)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pid    (in_pid),
        .in_tok    (in_tok),
        .in_len    (in_len),
        .in_data   (in_data),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .pkt_done  (pkt_done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endfunction

    // Textbook serial CRC over msg_q, preset to all ones.
    function automatic logic [15:0] crc_ref(input int w, input logic [15:0] poly);
        logic [15:0] mask = 16'((32'd1 << w) - 1);
        logic [15:0] r = mask;
        for (int i = 0; i < msg_q.size(); i++) begin
            bit top = r[w-1];
            r = (r << 1) & mask;
            if (top ^ msg_q[i]) r = r ^ poly;
        end
        return r;
    endfunction

    function automatic void build_exp(input logic [3:0] pid, input logic [10:0] tok,
                                      input int len, input logic [DW-1:0] data);
        logic [15:0] c;
        int eff;
        exp_q.delete();
        msg_q.delete();
        push_byte(8'h80);
        push_byte({~pid, pid});
        if (pid[1:0] == 2'b01) begin
            for (int i = 0; i < 11; i++) msg_q.push_back(tok[i]);
            foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
            c = crc_ref(5, 16'h0005);
            for (int i = 4; i >= 0; i--) exp_q.push_back(~c[i]);
        end else if (pid[1:0] == 2'b11) begin
            eff = (len > MB) ? MB : len;
            for (int i = 0; i < 8 * eff; i++) msg_q.push_back(data[i]);
            foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
            c = crc_ref(16, 16'h8005);
            for (int i = 15; i >= 0; i--) exp_q.push_back(~c[i]);
        end
    endfunction

    task automatic rand_data(output logic [DW-1:0] d);
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    endtask

    task automatic accept(input logic [3:0] pid, input logic [10:0] tok, input int len,
                          input logic [DW-1:0] data, input bit want_err);
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_pid   = pid;
        in_tok   = tok;
        in_len   = LW'(len);
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        chk("len_err", len_err, want_err);
    endtask

    // Entered on the negedge right after acceptance; collects accepted bits.
    task automatic stream(input bit stall, input string name);
        bit got_q[$];
        int cyc = 0;
        int last_cnt = 0;
        int last_idx = -1;
        int unstable = 0;
        int mism = 0;
        int n;
        bit pv_stall = 0;
        bit pv_bit = 0;
        bit pv_last = 0;
        chk({name, "_start"}, out_valid, 1);
        while (got_q.size() < exp_q.size() && cyc < 4 * exp_q.size() + 50) begin
            if (cyc == 1) chk({name, "_len_err_pulse"}, len_err, 0);
            if (!out_valid) break;
            if (pv_stall && (out_bit !== pv_bit || out_last !== pv_last)) unstable++;
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (out_ready) begin
                if (out_last) begin
                    last_cnt++;
                    last_idx = got_q.size();
                end
                got_q.push_back(out_bit);
            end
            pv_stall = !out_ready;
            pv_bit   = out_bit;
            pv_last  = out_last;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) mism++;
        chk({name, "_nbits"}, got_q.size(), exp_q.size());
        chk({name, "_bits"}, mism, 0);
        chk({name, "_last_cnt"}, last_cnt, 1);
        chk({name, "_last_pos"}, last_idx, exp_q.size() - 1);
        chk({name, "_stall_stable"}, unstable, 0);
        if (!stall) chk({name, "_cycles"}, cyc, exp_q.size());
        chk({name, "_end_valid"}, out_valid, 0);
        chk({name, "_done"}, pkt_done, 1);
        chk({name, "_end_ready"}, in_ready, 1);
        @(negedge clk);
        chk({name, "_done_pulse"}, pkt_done, 0);
        $display("pkt %s: bits=%0d cycles=%0d mism=%0d", name, got_q.size(), cyc, mism);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] d2;
        logic [3:0]    p;
        logic [10:0]   t;
        int            l;
        int            dcnt;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bit", out_bit, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_len_err", len_err, 0);
        rst_b = 1'b1;
        @(negedge clk);

        // Known wire vectors
        exp_q.delete(); push_byte(8'h80); push_byte(8'hD2);
        accept(4'b0010, 11'd0, 0, '0, 0);
        stream(0, "ack");

        exp_q.delete(); push_byte(8'h80); push_byte(8'h2D); push_byte(8'h00); push_byte(8'h10);
        accept(4'b1101, 11'd0, 0, '0, 0);
        stream(0, "setup");

        exp_q.delete(); push_byte(8'h80); push_byte(8'hC3); push_byte(8'h00); push_byte(8'h00);
        accept(4'b0011, 11'd0, 0, '0, 0);
        stream(0, "data0_empty");

        exp_q.delete(); push_byte(8'h80); push_byte(8'h4B); push_byte(8'h00); push_byte(8'h00);
        accept(4'b1011, 11'd0, 0, '0, 0);
        stream(1, "data1_empty");

        // Full-size payload under random backpressure
        rand_data(d);
        build_exp(4'b0011, 11'd0, MB, d);
        accept(4'b0011, 11'd0, MB, d, 0);
        stream(1, "data0_max");

        // Random descriptors of every class
        for (int k = 0; k < 8; k++) begin
            p = 4'($urandom_range(0, 15));
            t = 11'($urandom);
            l = $urandom_range(0, 12);
            rand_data(d);
            build_exp(p, t, l, d);
            accept(p, t, l, d, 0);
            stream(k[0], "rand");
        end

        // Oversize length is clamped
        rand_data(d);
        build_exp(4'b0011, 11'd0, MB + 1, d);
        accept(4'b0011, 11'd0, MB + 1, d, 1);
        stream(1, "oversize");

        // Reset in the middle of the payload
        rand_data(d);
        accept(4'b1011, 11'd0, 8, d, 0);
        repeat (20) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_out_bit", out_bit, 0);
        @(negedge clk);
        rst_b = 1'b1;
        dcnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (pkt_done) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);

        // Back-to-back: in_valid held across the first packet
        rand_data(d);
        rand_data(d2);
        build_exp(4'b0011, 11'd0, 5, d);
        chk("b2b_ready", in_ready, 1);
        in_valid = 1'b1;
        in_pid   = 4'b0011;
        in_len   = LW'(5);
        in_data  = d;
        @(negedge clk);
        in_pid   = 4'b1011;
        in_len   = LW'(7);
        in_data  = d2;
        stream(0, "b2b_first");
        chk("b2b_second_busy", in_ready, 0);
        chk("b2b_second_valid", out_valid, 1);
        in_valid = 1'b0;
        build_exp(4'b1011, 11'd0, 7, d2);
        stream(1, "b2b_second");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_pkt_serializer.md
# usb_pkt_serializer

Parametrised USB packet encoder for the transmit path: it accepts a packet descriptor (PID, token field, up to MAX_BYTES payload bytes), then emits SYNC, PID, fields and CRC as a serial NRZ bit stream, LSB-first. The CRC is computed on the fly while bits are shifted, so there is no pre-calculation stall. It sits between the protocol FSM and the bit-stuffer/NRZI stage. The bit-level valid/ready handshake on its output lets downstream stall it for stuffed bits.

## Interface
- MAX_BYTES, 64: maximum data-packet payload in bytes (1..1023)
- LEN_W, $clog2(MAX_BYTES+1): width of the payload length field
- clk  input  1  system clock
- rst_b  input  1  asynchronous, active-low reset
- in_valid  input  1  descriptor valid
- in_ready  output  1  encoder can accept a descriptor (IDLE only)
- in_pid  input  4  PID, 4-bit code (for example OUT=0001, DATA0=0011, ACK=0010)
- in_tok  input  11  token field {endp[3:0], addr[6:0]}, or the SOF frame number
- in_len  input  LEN_W  payload byte count (data PIDs only)
- in_data  input  8*MAX_BYTES  payload; byte i is in_data[8i+7:8i]
- out_bit  output  1  serial NRZ bit
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream accepts out_bit this cycle
- out_last  output  1  out_bit is the final bit of the packet
- pkt_done  output  1  one-cycle pulse after the final bit is accepted
- len_err  output  1  one-cycle pulse: in_len > MAX_BYTES at acceptance

## Operation
- PID class, decided from in_pid[1:0]:
  - 01: token, carries an 11-bit field and CRC5 (OUT, IN, SOF, SETUP).
  - 11: data, carries the payload and CRC16.
  - 10 or 00: PID only (handshakes and special PIDs).
- Acceptance happens on in_valid && in_ready:
  - Latch the full descriptor.
  - Preset the CRC5 register to 5'b11111 and the CRC16 register to 16'hFFFF.
  - If in_len > MAX_BYTES, clamp the length to MAX_BYTES and pulse len_err.
- States and bit order:
  - IDLE
  - SYNC: 8 bits, 0,0,0,0,0,0,0,1.
  - PID: 8 bits, in_pid[0..3], then ~in_pid[0..3].
  - TOK: 11 bits, in_tok[0..10].
  - CRC5: 5 bits, ~crc5[4] down to ~crc5[0].
  - DATA: 8*len bits, byte 0 first, each byte LSB-first.
  - CRC16: 16 bits, ~crc16[15] down to ~crc16[0].
- Transitions:
  - IDLE to SYNC on acceptance.
  - SYNC to PID.
  - PID to TOK for tokens, to DATA for data (to CRC16 directly when len = 0), to IDLE for PID-only packets.
  - TOK to CRC5 to IDLE.
  - DATA to CRC16 to IDLE.
- A state advances only when its final bit is accepted (out_valid && out_ready).
- CRC update: the LFSR steps only on an accepted TOK or DATA bit.
  - CRC5 polynomial x^5+x^2+1; CRC16 polynomial x^16+x^15+x^2+1.
  - Feedback: fb = crc[MSB] ^ bit; shift left; XOR fb into bit 0 and the polynomial taps.
- A single bit counter, width $clog2(8*MAX_BYTES+1), counts down the bits left in the current field. It reloads on each state entry; at zero the state advances. No wrap-around is allowed.
- out_last is high during the final bit of: CRC5, CRC16, or PID for PID-only packets.

## Timing
- Reset values: in_ready=1, out_valid=0, out_bit=0, out_last=0, pkt_done=0, len_err=0, state IDLE, CRCs all ones.
- Accept at edge T: out_valid=1 with the first SYNC bit from T+1.
- out_bit and out_last are held stable while out_valid && !out_ready.
- Bit count per packet: 32 for a token, 32+8*len for data, 16 for PID-only.
- At zero stall the packet takes exactly that many cycles.
- On the edge where the final bit is accepted:
  - state goes to IDLE and out_valid drops;
  - pkt_done and in_ready are high the next cycle.
- So back-to-back packets have one bubble cycle.
- in_ready is 0 in every non-IDLE state; in_valid there is ignored and the descriptor is not latched.
- Reset mid-packet: all outputs return to reset values asynchronously. No partial CRC is emitted and pkt_done does not fire.

## Structure
- Package usb_enc_pkg holds:
  - the state enum and the PID class enum (TOKEN, DATA, PID_ONLY);
  - constants SYNC_PATTERN=8'h80, CRC5_POLY=5'b00101, CRC16_POLY=16'h8005, CRC5_INIT, CRC16_INIT.
- Sub-module usb_crc_lfsr is parametrised on WIDTH, POLY and INIT, with ports clk, rst_b, clr, en, bit_in, crc. It is instantiated twice, once for CRC5 and once for CRC16.
- Top level: FSM, bit counter, descriptor registers, output mux.

## Test plan
- ACK, in_pid=0010, out_ready=1: 16 bits, SYNC then byte D2 LSB-first. out_last on bit 16; pkt_done at accept+17.
- SETUP, in_pid=1101, in_tok=0: wire bytes after SYNC are 2D 00 10. CRC5 bits emitted are 0,1,0,0,0; 32 bits total.
- DATA0, in_len=0: wire bytes C3 00 00. DATA1, in_len=0: wire bytes 4B 00 00.
- DATA0, in_len=MAX_BYTES, random data, out_ready toggled randomly:
  - the bit stream matches a reference-model CRC16;
  - out_bit is stable during every stall.
- in_len=MAX_BYTES+1: len_err pulses once and exactly MAX_BYTES bytes are sent. Next, rst_b is asserted during DATA: out_valid drops immediately, in_ready=1, and no pkt_done.
- Two back-to-back descriptors (in_valid held high): the second is accepted exactly one cycle after pkt_done's preceding final bit. Both CRCs are correct, which also checks the preset on re-acceptance.
